operand_feeder: RTL

OPERAND_FEEDER -- requirements
Module: operand_feeder

---
 rtl/operand_feeder_pkg.sv | 27 ++
 rtl/operand_feeder_if.sv | 26 ++
 rtl/operand_feeder_pair_fifo.sv | 64 ++++++
 rtl/operand_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_feeder_pkg.sv
// Shared types and constants for the operand feeder: FSM state encoding,
// default geometry, and operand/instruction widths.
package operand_feeder_pkg;

  localparam int DEPTH_DEF   = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int INSTR_W     = 3;
  localparam int DATA_W      = 8;
  localparam int PAIR_W      = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_STREAM = 3'd2,
    S_GAP    = 3'd3,
    S_LAST   = 3'd4,
    S_WAIT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Operand A occupies the upper byte of a buffered pair.
  function automatic logic [PAIR_W-1:0] pack_pair(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    return {a, b};
  endfunction

endpackage

// File: rtl/operand_feeder_if.sv
// Downstream handshake between the operand feeder (master) and the
// max-finder (slave).
interface operand_feeder_if;
  import operand_feeder_pkg::*;

  logic               start;
  logic               valid;
  logic               one_left;
  logic [DATA_W-1:0]  Data_A;
  logic [DATA_W-1:0]  Data_B;
  logic [INSTR_W-1:0] instruction;
  logic               stall;
  logic               finish;
  logic [DATA_W-1:0]  maximum;

  modport master (
    output start, valid, one_left, Data_A, Data_B, instruction,
    input  stall, finish, maximum
  );

  modport slave (
    input  start, valid, one_left, Data_A, Data_B, instruction,
    output stall, finish, maximum
  );

endinterface

// File: rtl/operand_feeder_pair_fifo.sv
// Circular buffer of operand pairs; reset empties it by clearing the
// pointers and the occupancy count.
module pair_fifo
  import operand_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [PAIR_W-1:0]      din_i,
  input  logic                   pop_i,
  output logic [PAIR_W-1:0]      dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PAIR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign dout_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pair storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// Buffers host operand pairs and streams them to a downstream max-finder,
// inserting a two-cycle gap before the final pair and waiting for its result.
module operand_feeder
  import operand_feeder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [DATA_W-1:0]      wr_a_i,
  input  logic [DATA_W-1:0]      wr_b_i,
  input  logic                   go_i,
  input  logic [INSTR_W-1:0]     instr_in_i,
  operand_feeder_if.master       ds,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [DATA_W-1:0]      result_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               gap_q, gap_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               start_q, start_d;
  logic               valid_q, valid_d;
  logic               one_left_q, one_left_d;
  logic [DATA_W-1:0]  data_a_q, data_a_d;
  logic [DATA_W-1:0]  data_b_q, data_b_d;
  logic [INSTR_W-1:0] instruction_q, instruction_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  result_q, result_d;

  logic               push_s;
  logic               pop_s;
  logic [PAIR_W-1:0]  head_s;
  logic [CW-1:0]      count_s;
  logic               full_s;
  logic               empty_s;

  assign push_s = wr_en_i && !full_s && (state_q == S_IDLE);

  pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .din_i   (pack_pair(wr_a_i, wr_b_i)),
    .pop_i   (pop_s),
    .dout_o  (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Next state and next registered outputs; outputs reflect the state being left.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    gap_d         = gap_q;
    timer_d       = timer_q;
    start_d       = 1'b0;
    valid_d       = 1'b0;
    one_left_d    = 1'b0;
    data_a_d      = '0;
    data_b_d      = '0;
    instruction_d = instr_q;
    busy_d        = 1'b1;
    done_d        = 1'b0;
    err_d         = err_q;
    result_d      = result_q;
    pop_s         = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d        = 1'b0;
        instruction_d = '0;
        if (go_i && !empty_s) begin
          state_d = S_START;
          instr_d = instr_in_i;
          err_d   = 1'b0;
          gap_d   = 1'b0;
          timer_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        start_d = 1'b1;
        if (count_s >= CW'(2)) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_GAP;
        end
      end
      S_STREAM: begin
        if (!ds.stall) begin
          valid_d  = 1'b1;
          data_a_d = head_s[PAIR_W-1:DATA_W];
          data_b_d = head_s[DATA_W-1:0];
          pop_s    = 1'b1;
          // Popping from two entries leaves only the final pair.
          if (count_s == CW'(2)) begin
            state_d = S_GAP;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_GAP: begin
        one_left_d = 1'b1;
        if (gap_q) begin
          gap_d   = 1'b0;
          state_d = S_LAST;
        end else begin
          gap_d   = 1'b1;
          state_d = S_GAP;
        end
      end
      S_LAST: begin
        one_left_d = 1'b1;
        if (!ds.stall) begin
          valid_d  = 1'b1;
          data_a_d = head_s[PAIR_W-1:DATA_W];
          data_b_d = head_s[DATA_W-1:0];
          pop_s    = 1'b1;
          timer_d  = '0;
          state_d  = S_WAIT;
        end else begin
          state_d = S_LAST;
        end
      end
      S_WAIT: begin
        if (ds.finish) begin
          result_d = ds.maximum;
          state_d  = S_DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d        = 1'b0;
        instruction_d = '0;
        state_d       = S_IDLE;
      end
    endcase
  end

  // State and output registers, all cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      gap_q         <= 1'b0;
      timer_q       <= '0;
      start_q       <= 1'b0;
      valid_q       <= 1'b0;
      one_left_q    <= 1'b0;
      data_a_q      <= '0;
      data_b_q      <= '0;
      instruction_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      gap_q         <= gap_d;
      timer_q       <= timer_d;
      start_q       <= start_d;
      valid_q       <= valid_d;
      one_left_q    <= one_left_d;
      data_a_q      <= data_a_d;
      data_b_q      <= data_b_d;
      instruction_q <= instruction_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      result_q      <= result_d;
    end
  end

  assign ds.start       = start_q;
  assign ds.valid       = valid_q;
  assign ds.one_left    = one_left_q;
  assign ds.Data_A      = data_a_q;
  assign ds.Data_B      = data_b_q;
  assign ds.instruction = instruction_q;
  assign full_o         = full_s;
  assign count_o        = count_s;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign result_o       = result_q;

endmodule
